// File: rtl/nes_ppu_pkg.sv
// Shared PPU constants, types and coordinate-to-attribute mapping helpers.
// No ports; imported by the attribute palette selector and its sub-modules.
package nes_ppu_pkg;

    localparam int unsigned ATTR_AW        = 7;
    localparam int unsigned COORD_W        = 8;
    localparam int unsigned ROWS_VIS       = 240;
    localparam int unsigned COLS_VIS       = 256;
    localparam int unsigned ATTR_BLK_SHIFT = 5;
    localparam int unsigned ATTR_QUAD_BIT  = 4;

    typedef logic [1:0]         pal_idx_t;
    typedef logic [ATTR_AW-1:0] attr_addr_t;
    typedef logic [COORD_W-1:0] coord_t;

    // One attribute byte covers a 32x32 pixel block; addr[6] is always 0.
    function automatic attr_addr_t attr_addr_map(input coord_t col, input coord_t row);
        return attr_addr_t'({row[COORD_W-1:ATTR_BLK_SHIFT], col[COORD_W-1:ATTR_BLK_SHIFT]});
    endfunction

    // 16x16 quadrant inside the block: {bottom, right}.
    function automatic logic [1:0] attr_quad_map(input coord_t col, input coord_t row);
        return {row[ATTR_QUAD_BIT], col[ATTR_QUAD_BIT]};
    endfunction

endpackage

// File: rtl/nes_attr_palette_sel_if.sv
// Bus bundle for the attribute palette selector.
// Carries: ce, pixel coordinate input (vld_in/col/row), attribute ROM
// port (atable_addr/atable_dout) and aligned output (vld_out/pal_idx/col_out/row_out).
// master = environment (renderer, ROM, mixer); slave = selector.
interface nes_attr_palette_sel_if;
    import nes_ppu_pkg::*;

    logic       ce;
    logic       vld_in;
    coord_t     col;
    coord_t     row;
    attr_addr_t atable_addr;
    logic [7:0] atable_dout;
    logic       vld_out;
    pal_idx_t   pal_idx;
    coord_t     col_out;
    coord_t     row_out;

    modport master (
        output ce, vld_in, col, row, atable_dout,
        input  atable_addr, vld_out, pal_idx, col_out, row_out
    );

    modport slave (
        input  ce, vld_in, col, row, atable_dout,
        output atable_addr, vld_out, pal_idx, col_out, row_out
    );

endinterface

// File: rtl/nes_attr_quad_sel.sv
// Combinational 2-bit field select from an attribute byte.
// Ports: attr_byte (8b attribute), quad (2b {bottom,right}), field_c (2b palette).
module nes_attr_quad_sel
    import nes_ppu_pkg::*;
(
    input  logic [7:0] attr_byte,
    input  logic [1:0] quad,
    output pal_idx_t   field_c
);

    // 00=TL [1:0], 01=TR [3:2], 10=BL [5:4], 11=BR [7:6]
    always_comb begin
        field_c = attr_byte[1:0];
        case (quad)
            2'b00: field_c = attr_byte[1:0];
            2'b01: field_c = attr_byte[3:2];
            2'b10: field_c = attr_byte[5:4];
            2'b11: field_c = attr_byte[7:6];
            default: field_c = attr_byte[1:0];
        endcase
    end

endmodule

// File: rtl/nes_attr_palette_sel.sv
// Background attribute palette selector: maps pixel coordinates to an
// attribute ROM address, absorbs the ROM's 1-clk read latency and emits a
// valid-tagged 2-bit palette index aligned with delayed coordinates.
// Ports: clk, rst (sync, active-high), bus (slave modport of
// nes_attr_palette_sel_if: ce, vld_in, col, row, atable_addr, atable_dout,
// vld_out, pal_idx, col_out, row_out).
// Optional: define NES_ATTR_BLANK_ZERO_EN to force pal_idx/col_out/row_out
// to 0 on bubbles.
module nes_attr_palette_sel
    import nes_ppu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    nes_attr_palette_sel_if.slave   bus
);

    attr_addr_t addr_c;
    logic [1:0] quad_c;
    logic       clip_c;

    logic       vld1;
    attr_addr_t addr1;
    logic [1:0] quad1;
    logic       clip1;
    coord_t     col1;
    coord_t     row1;

    pal_idx_t   field_c;

    assign addr_c = attr_addr_map(bus.col, bus.row);
    assign quad_c = attr_quad_map(bus.col, bus.row);
    assign clip_c = (bus.row >= COORD_W'(ROWS_VIS));

    // During a stall the ROM keeps re-reading addr1, so atable_dout stays
    // on the in-flight byte and no skid buffer is needed.
    assign bus.atable_addr = bus.ce ? addr_c : addr1;

    // S1: coordinate and address stage, aligned with the ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1  <= 1'b0;
            addr1 <= '0;
            quad1 <= '0;
            clip1 <= 1'b0;
            col1  <= '0;
            row1  <= '0;
        end else if (bus.ce) begin
            vld1  <= bus.vld_in;
            addr1 <= addr_c;
            quad1 <= quad_c;
            clip1 <= clip_c;
            col1  <= bus.col;
            row1  <= bus.row;
        end
    end

    nes_attr_quad_sel u_quad_sel (
        .attr_byte (bus.atable_dout),
        .quad      (quad1),
        .field_c   (field_c)
    );

    // S2: registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vld_out <= 1'b0;
            bus.pal_idx <= '0;
            bus.col_out <= '0;
            bus.row_out <= '0;
        end else if (bus.ce) begin
            bus.vld_out <= vld1;
`ifdef NES_ATTR_BLANK_ZERO_EN
            if (!vld1) begin
                bus.pal_idx <= '0;
                bus.col_out <= '0;
                bus.row_out <= '0;
            end else begin
                bus.pal_idx <= clip1 ? 2'b00 : field_c;
                bus.col_out <= col1;
                bus.row_out <= row1;
            end
`else
            bus.pal_idx <= clip1 ? 2'b00 : field_c;
            bus.col_out <= col1;
            bus.row_out <= row1;
`endif
        end
    end

endmodule

// File: tb/tb_nes_attr_palette_sel.sv
// Self-checking bench for nes_attr_palette_sel with a 1-clk registered
// attribute ROM model.
module tb_nes_attr_palette_sel;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef NES_ATTR_BLANK_ZERO_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    nes_attr_palette_sel_if bus ();

    nes_attr_palette_sel dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents; addr 56 (rows 224..255, cols 0..31) holds 0xFF so that
    // row clipping is observable against a non-zero byte.
    function automatic logic [7:0] rom_rd(input logic [6:0] a);
        case (a)
            7'd0:    return 8'h15;
            7'd5:    return 8'h45;
            7'd9:    return 8'h40;
            7'd56:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) bus.atable_dout <= rom_rd(bus.atable_addr);

    typedef struct {
        logic       vld;
        logic [7:0] col;
        logic [7:0] row;
        logic [6:0] exp_addr;
        logic [1:0] exp_pal;
    } vec_t;

    localparam int N = 12;
    vec_t vecs [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ce, input logic vld, input logic [7:0] c, input logic [7:0] r);
        bus.ce     = ce;
        bus.vld_in = vld;
        bus.col    = c;
        bus.row    = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [1:0] p,
                           input logic [7:0] c, input logic [7:0] r);
        chk({nm, "_vld"}, 32'(bus.vld_out), 32'(v));
        chk({nm, "_pal"}, 32'(bus.pal_idx), 32'(p));
        chk({nm, "_col"}, 32'(bus.col_out), 32'(c));
        chk({nm, "_row"}, 32'(bus.row_out), 32'(r));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b1, 8'd0,   8'd0,   7'd0,  2'd1};
        vecs[1]  = '{1'b1, 8'd16,  8'd0,   7'd0,  2'd1};
        vecs[2]  = '{1'b1, 8'd0,   8'd16,  7'd0,  2'd1};
        vecs[3]  = '{1'b1, 8'd16,  8'd16,  7'd0,  2'd0};
        vecs[4]  = '{1'b1, 8'd176, 8'd16,  7'd5,  2'd1};
        vecs[5]  = '{1'b1, 8'd48,  8'd48,  7'd9,  2'd1};
        vecs[6]  = '{1'b1, 8'd32,  8'd32,  7'd9,  2'd0};
        vecs[7]  = '{1'b1, 8'd0,   8'd239, 7'd56, 2'd3};
        vecs[8]  = '{1'b1, 8'd0,   8'd240, 7'd56, 2'd0};
        vecs[9]  = '{1'b1, 8'd16,  8'd0,   7'd0,  2'd1};
        vecs[10] = '{1'b0, 8'd16,  8'd0,   7'd0,  2'd1};
        vecs[11] = '{1'b1, 8'd0,   8'd16,  7'd0,  2'd1};

        // Reset has priority over ce.
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'd16, 8'd16);
        step();
        step();
        chk_out("reset", 1'b0, 2'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 8'd176, 8'd16);
        #1;
        chk("reset_stall_addr", 32'(bus.atable_addr), 32'd0);
        rst = 1'b0;
        step();
        chk("post_reset_stall_addr", 32'(bus.atable_addr), 32'd0);
        chk_out("post_reset_stall", 1'b0, 2'd0, 8'd0, 8'd0);

        // Streaming table: outputs of vector s appear two clocks later.
        for (int s = 0; s < N + 2; s++) begin
            if (s >= 2) begin
                if (vecs[s-2].vld) begin
                    chk_out($sformatf("vec%0d", s - 2), 1'b1, vecs[s-2].exp_pal,
                            vecs[s-2].col, vecs[s-2].row);
                end else begin
                    chk($sformatf("vec%0d_vld", s - 2), 32'(bus.vld_out), 32'd0);
                    if (BLANK) chk_out($sformatf("vec%0d_blank", s - 2), 1'b0, 2'd0, 8'd0, 8'd0);
                end
            end
            if (s < N) begin
                drive(1'b1, vecs[s].vld, vecs[s].col, vecs[s].row);
                #1;
                chk($sformatf("vec%0d_addr", s), 32'(bus.atable_addr), 32'(vecs[s].exp_addr));
            end else begin
                drive(1'b1, 1'b0, 8'd0, 8'd0);
            end
            step();
        end

        // Stall: (0,0) in S1, (48,48) in S2, then ce low for 3 clocks.
        drive(1'b1, 1'b1, 8'd48, 8'd48);
        step();
        drive(1'b1, 1'b1, 8'd0, 8'd0);
        step();
        chk_out("pre_stall", 1'b1, 2'd1, 8'd48, 8'd48);
        drive(1'b0, 1'b1, 8'd176, 8'd16);
        #1;
        chk("stall_addr", 32'(bus.atable_addr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_addr", k), 32'(bus.atable_addr), 32'd0);
            chk_out($sformatf("stall%0d", k), 1'b1, 2'd1, 8'd48, 8'd48);
        end
        bus.ce = 1'b1;
        #1;
        chk("resume_addr", 32'(bus.atable_addr), 32'd5);
        step();
        chk_out("resume0", 1'b1, 2'd1, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        step();
        chk_out("resume1", 1'b1, 2'd1, 8'd176, 8'd16);
        step();
        chk("drain_vld", 32'(bus.vld_out), 32'd0);

        // Reset mid-stream, asserted with ce low.
        drive(1'b1, 1'b1, 8'd16, 8'd0);
        step();
        drive(1'b1, 1'b1, 8'd0, 8'd16);
        step();
        chk_out("pre_rst", 1'b1, 2'd1, 8'd16, 8'd0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'd176, 8'd16);
        step();
        chk_out("mid_rst", 1'b0, 2'd0, 8'd0, 8'd0);
        chk("mid_rst_addr", 32'(bus.atable_addr), 32'd0);
        rst = 1'b0;
        bus.ce = 1'b1;
        step();
        chk("restart_lat1_vld", 32'(bus.vld_out), 32'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        step();
        chk_out("restart", 1'b1, 2'd1, 8'd176, 8'd16);
        step();
        chk("restart_drain_vld", 32'(bus.vld_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
